fdivr2_iterunit: RTL
====================

# fdivr2_iterunit

Radix-2 SRT iteration engine that sits directly upstream of the radix-2 unified on-the-fly converter in the divsqrt unit. It performs the residual recurrence, selects one signed quotient digit {-1,0,+1} per cycle, and accumulates U/UM with the on-the-fly update rule. A final correction cycle produces an exact non-redundant quotient and remainder. It computes division only; sqrt stays in the full unit.

## Interface
- N, 16, operand width; operands are normalized fractions in [1/2,1).
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  synchronous flush; returns to IDLE from any state.
- X  in  N  dividend fraction; X[N-1] must be 1.
- D  in  N  divisor fraction; D[N-1] must be 1.
- busy  out  1  high in ITER and FIX.
- done  out  1  one-cycle pulse; Q/Rem valid from that cycle on.
- err  out  1  one-cycle pulse; start was refused because of an unnormalized operand.
- Q  out  N+1  quotient, floor((X<<N)/D).
- Rem  out  N  remainder, (X<<N) - Q*D, with 0 <= Rem < D.

## Operation
- States: IDLE, ITER, FIX.
  - IDLE: if start=1 and X[N-1]&D[N-1]=1, go to ITER. If start=1 and either MSB=0, pulse err, stay in IDLE, and leave Q/Rem unchanged.
  - ITER: runs N+1 iterations, then goes to FIX. FIX then goes to IDLE and pulses done.
- Start capture:
  - D is latched.
  - Residual W is N+4-bit two's complement: 3 integer bits (including sign) and N+1 fraction bits. W0 = X/2.
  - U = UM = 0. Thermometer/position register C points at the MSB of the N+1-bit quotient.
  - Iteration counter = N.
- Digit selection on 2W:
  - est = 2W truncated to 1/2 resolution (top 4 bits).
  - q = +1 if est >= 1/2; q = -1 if est <= -1; otherwise q = 0.
- Recurrence: W <= 2W - q*D, with D zero-extended and aligned to the fraction. Invariant |W| <= D always holds; a violation is a bug.
- On-the-fly update at position bit K (one-hot from C):
  - q=+1: U <= U|K, UM <= U.
  - q=-1: U <= UM|K, UM <= UM.
  - q=0: U <= U, UM <= UM|K.
  - C then shifts right one position.
- FIX:
  - If W < 0: Q <= UM and Rem <= (W + D) scaled.
  - Otherwise: Q <= U and Rem <= W scaled.
  - "Scaled" means the integer residual; the low fraction bits are exactly representable.
- abort in ITER/FIX: next state is IDLE, no done pulse, Q/Rem keep their previous values. abort in IDLE has no effect; abort has priority over start in the same cycle.
- start while busy=1 is ignored.

## Timing
- Reset values: state IDLE; busy=0, done=0, err=0; Q=0, Rem=0; internal W/U/UM/C/counter = 0.
- Start accepted at edge E0. ITER occupies the cycles after E0 through E(N+1). FIX occurs at edge E(N+2). done is high for the single cycle after E(N+2).
- Latency is N+2 cycles from accepting edge to done. The earliest next start is sampled in the done cycle, giving a throughput of one operation per N+2 cycles.
- busy is high from the cycle after E0 through the cycle before done.
- err is high for the one cycle after the refusing edge.
- Q/Rem are registered and stable between done pulses.
- reset_n low mid-operation forces all reset values immediately (asynchronous), with no done. The first start is accepted no earlier than the first rising edge after deassertion.

## Test plan
- N=16, X=0x8000, D=0x8000 -> done at cycle 18, Q=0x10000, Rem=0x0000.
- X=0x8000, D=0xC000 -> Q=0x0AAAA, Rem=0x8000. Digit stream must include -1 digits, exercising the W<0 correction.
- X=0xFFFF, D=0x8000 -> Q=0x1FFFE, Rem=0.
- X=0x8000, D=0xFFFF -> Q=0x08000, Rem=0x8000.
- Handshake/refusal:
  - start with D=0x7FFF -> err pulse, busy stays 0, Q/Rem unchanged.
  - start held high during busy -> only one operation.
  - back-to-back start in the done cycle -> second done 18 cycles later.
- Interruption:
  - abort at iteration 5 -> IDLE next cycle, no done, previous Q/Rem held.
  - reset_n pulsed low mid-ITER -> all outputs 0 asynchronously.
  - Random normalized X/D (10k) vs. reference floor((X<<16)/D), with the |W| <= D assertion enabled every cycle.

Source files
------------

// File: rtl/fdivr2_iterunit.sv
// Radix-2 SRT divider iteration engine with on-the-fly quotient conversion and final correction.
// Latency: N+2 cycles from the accepting edge to the done pulse; one operation per N+2 cycles.
// No backpressure: start is only sampled in IDLE and ignored while busy; abort flushes to IDLE.
module fdivr2_iterunit #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] X,
  input  logic [N-1:0] D,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N:0]   Q,
  output logic [N-1:0] Rem
);

  // Residual: 3 integer bits (incl. sign) + N+1 fraction bits.
  localparam int WW = N + 4;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  d_q, d_d;
  logic [WW-1:0] w_q, w_d;
  logic [N:0]    u_q, u_d;
  logic [N:0]    um_q, um_d;
  logic [N:0]    c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Datapath signals for one recurrence step.
  logic [WW-1:0]      w2;
  logic signed [3:0]  est;
  logic [WW-1:0]      dfrac;
  logic               q_pos;
  logic               q_neg;
  logic [WW-1:0]      w_next;
  logic [N:0]         u_next;
  logic [N:0]         um_next;

  // Correction and bound-check signals.
  logic               w_neg;
  logic [WW-1:0]      fix_sum;
  logic [N-1:0]       rem_fix;
  logic [N:0]         quo_fix;
  logic [WW-1:0]      w_mag;
  logic               w_in_bound;
  logic               unused_fix_bits;

  // 2W drops the top sign bit; |W| <= D < 1 keeps 2W inside the 3-bit integer range.
  assign w2    = {w_q[WW-2:0], 1'b0};
  // Estimate is 2W truncated to 1/2 units: 3 integer bits plus the first fraction bit.
  assign est   = w2[WW-1 -: 4];
  // Divisor as an N+1-bit fraction, zero-extended into the residual format.
  assign dfrac = {3'b000, d_q, 1'b0};

  // q=+1 when est >= 1/2, q=-1 when est <= -1, else q=0.
  assign q_pos = (est >= 4'sd1);
  assign q_neg = (est <= -4'sd2);

  // Residual recurrence and on-the-fly U/UM update (UM tracks U minus one ulp at C).
  always_comb begin
    w_next  = w2;
    u_next  = u_q;
    um_next = um_q | c_q;
    if (q_pos) begin
      w_next  = w2 - dfrac;
      u_next  = u_q | c_q;
      um_next = u_q;
    end else if (q_neg) begin
      w_next  = w2 + dfrac;
      u_next  = um_q | c_q;
      um_next = um_q;
    end
  end

  // A negative final residual means U overshot by one; take UM and add D back.
  assign w_neg   = w_q[WW-1];
  assign fix_sum = w_neg ? (w_q + dfrac) : w_q;
  // The residual LSB is always zero after N+1 steps, so bits [N:1] are the integer remainder.
  assign rem_fix = fix_sum[N:1];
  assign quo_fix = w_neg ? um_q : u_q;
  assign unused_fix_bits = ^{fix_sum[WW-1:N+1], fix_sum[0]};

  // Residual magnitude against D, both in N+1-bit fraction units.
  assign w_mag      = w_neg ? (-w_q) : w_q;
  assign w_in_bound = (w_mag <= dfrac);

  // Control FSM and next-state for all registers.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    w_d     = w_q;
    u_d     = u_q;
    um_d    = um_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (X[N-1] && D[N-1]) begin
            state_d = S_ITER;
            d_d     = D;
            w_d     = {4'b0000, X};
            u_d     = '0;
            um_d    = '0;
            c_d     = {1'b1, {N{1'b0}}};
            cnt_d   = CW'(N);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ITER: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          w_d  = w_next;
          u_d  = u_next;
          um_d = um_next;
          c_d  = c_q >> 1;
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!abort) begin
          quo_d  = quo_fix;
          rem_d  = rem_fix;
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      w_q     <= '0;
      u_q     <= '0;
      um_q    <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      w_q     <= w_d;
      u_q     <= u_d;
      um_q    <= um_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // The SRT selection keeps |W| <= D at all times; anything else is a datapath bug.
  a_w_bound: assert property (@(posedge clk) disable iff (!reset_n) w_in_bound);

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign err  = err_q;
  assign Q    = quo_q;
  assign Rem  = rem_q;

endmodule
